// File: rtl/rsa_bridge_pkg.sv
// ----------------------------------------------------------------------------
// rsa_bridge_pkg
// Shared types and constants for the UART <-> RSA-256 core Avalon-MM bridge.
//   top_state_e  : field/core sequencing states of rsa_avalon_bridge
//   port_phase_e : phases of one polled UART byte transfer (uart_byte_port)
//   *_DEF        : default register offsets, status bit indices, byte counts
// ----------------------------------------------------------------------------
package rsa_bridge_pkg;

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned FIELD_W = 256;
   localparam int unsigned CNT_W   = 6;

   localparam int unsigned KEY_BYTES_DEF   = 32;
   localparam int unsigned OUT_BYTES_DEF   = 31;
   localparam int unsigned RX_BASE_DEF     = 0;
   localparam int unsigned TX_BASE_DEF     = 4;
   localparam int unsigned STATUS_BASE_DEF = 8;
   localparam int unsigned RRDY_BIT_DEF    = 7;
   localparam int unsigned TRDY_BIT_DEF    = 6;

   typedef enum logic [2:0] {
      S_GET_N,
      S_GET_D,
      S_GET_A,
      S_START,
      S_WAIT,
      S_SEND
   } top_state_e;

   // P_IDLE is the dead cycle between transfers; a poll is launched from it.
   typedef enum logic [1:0] {
      P_IDLE,
      P_POLL,
      P_GAP,
      P_XFER
   } port_phase_e;

endpackage

// File: rtl/uart_byte_port.sv
// ----------------------------------------------------------------------------
// uart_byte_port
// Moves one byte between the bridge and the UART over Avalon-MM: polls the
// status register until RRDY (receive) or TRDY (transmit) is set, then reads
// the RX register or writes the TX register.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req            a byte transfer is wanted (sampled only between transfers)
//   i_dir            0 = receive, 1 = transmit (captured when the poll starts)
//   i_tx_byte        byte to send, sampled when the TX write is launched
//   o_done           high in the cycle the RX read / TX write completes
//   o_rx_byte        received byte, valid together with o_done
//   avm_*            Avalon-MM master signals (all registered)
// ----------------------------------------------------------------------------
module uart_byte_port
   import rsa_bridge_pkg::*;
#(
   parameter int unsigned RX_BASE     = RX_BASE_DEF,
   parameter int unsigned TX_BASE     = TX_BASE_DEF,
   parameter int unsigned STATUS_BASE = STATUS_BASE_DEF,
   parameter int unsigned RRDY_BIT    = RRDY_BIT_DEF,
   parameter int unsigned TRDY_BIT    = TRDY_BIT_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req,
   input  logic              i_dir,
   input  logic [7:0]        i_tx_byte,
   output logic              o_done,
   output logic [7:0]        o_rx_byte,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic              avm_waitrequest
);

   localparam logic [ADDR_W-1:0] ADDR_RX     = ADDR_W'(RX_BASE);
   localparam logic [ADDR_W-1:0] ADDR_TX     = ADDR_W'(TX_BASE);
   localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(STATUS_BASE);

   port_phase_e       phase_q;
   logic              dir_q;
   logic              read_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic ready;
   logic unused_rdata;

   assign ready        = dir_q ? avm_readdata[TRDY_BIT] : avm_readdata[RRDY_BIT];
   assign unused_rdata = ^avm_readdata;

   // Completion and read data are passed through in the completing cycle.
   assign o_done    = (phase_q == P_XFER) && !avm_waitrequest;
   assign o_rx_byte = avm_readdata[7:0];

   assign avm_address   = addr_q;
   assign avm_read      = read_q;
   assign avm_write     = write_q;
   assign avm_writedata = wdata_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_q <= P_IDLE;
         dir_q   <= 1'b0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= ADDR_STATUS;
         wdata_q <= '0;
      end else begin
         unique case (phase_q)
            P_IDLE: begin
               if (i_req) begin
                  dir_q   <= i_dir;
                  addr_q  <= ADDR_STATUS;
                  read_q  <= 1'b1;
                  phase_q <= P_POLL;
               end
            end
            P_POLL: begin
               if (!avm_waitrequest) begin
                  read_q  <= 1'b0;
                  // Bit clear: drop the request for one cycle and poll again.
                  phase_q <= ready ? P_GAP : P_IDLE;
               end
            end
            P_GAP: begin
               if (dir_q) begin
                  addr_q  <= ADDR_TX;
                  write_q <= 1'b1;
                  wdata_q <= {{(DATA_W-8){1'b0}}, i_tx_byte};
               end else begin
                  addr_q <= ADDR_RX;
                  read_q <= 1'b1;
               end
               phase_q <= P_XFER;
            end
            P_XFER: begin
               if (!avm_waitrequest) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  addr_q  <= ADDR_STATUS;
                  phase_q <= P_IDLE;
               end
            end
            default: phase_q <= P_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/rsa_avalon_bridge.sv
// ----------------------------------------------------------------------------
// rsa_avalon_bridge
// Avalon-MM master linking the RS-232 UART to the RSA-256 decryption core.
// Receives n, d and then a stream of ciphertext blocks MSB-first, starts the
// core on each block and transmits the low OUT_BYTES bytes of each result.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   avm_*              Avalon-MM master towards the UART registers
//   o_core_start       one-cycle start pulse to the core
//   o_core_a/d/n       ciphertext, private exponent, modulus
//   i_core_a_pow_d     plaintext result
//   i_core_finished    core done, only looked at while waiting for the core
// ----------------------------------------------------------------------------
module rsa_avalon_bridge
   import rsa_bridge_pkg::*;
#(
   parameter int unsigned KEY_BYTES   = KEY_BYTES_DEF,
   parameter int unsigned OUT_BYTES   = OUT_BYTES_DEF,
   parameter int unsigned RX_BASE     = RX_BASE_DEF,
   parameter int unsigned TX_BASE     = TX_BASE_DEF,
   parameter int unsigned STATUS_BASE = STATUS_BASE_DEF,
   parameter int unsigned RRDY_BIT    = RRDY_BIT_DEF,
   parameter int unsigned TRDY_BIT    = TRDY_BIT_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   output logic [ADDR_W-1:0]  avm_address,
   output logic               avm_read,
   input  logic [DATA_W-1:0]  avm_readdata,
   output logic               avm_write,
   output logic [DATA_W-1:0]  avm_writedata,
   input  logic               avm_waitrequest,
   output logic               o_core_start,
   output logic [FIELD_W-1:0] o_core_a,
   output logic [FIELD_W-1:0] o_core_d,
   output logic [FIELD_W-1:0] o_core_n,
   input  logic [FIELD_W-1:0] i_core_a_pow_d,
   input  logic               i_core_finished
);

   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
   localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BYTES - 1);

   top_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [FIELD_W-1:0] n_q;
   logic [FIELD_W-1:0] d_q;
   logic [FIELD_W-1:0] a_q;
   logic [FIELD_W-1:0] send_q;
   logic               start_q;

   logic       port_req;
   logic       port_dir;
   logic       port_done;
   logic [7:0] port_rx;
   logic       key_last;
   logic       out_last;

   assign key_last = (cnt_q == KEY_LAST);
   assign out_last = (cnt_q == OUT_LAST);

   assign o_core_start = start_q;
   assign o_core_a     = a_q;
   assign o_core_d     = d_q;
   assign o_core_n     = n_q;

   // The request is raised already in the cycle the core reports done, so the
   // first transmit poll goes out one cycle after that.
   always_comb begin
      port_req = 1'b0;
      port_dir = 1'b0;
      unique case (state_q)
         S_GET_N, S_GET_D, S_GET_A: port_req = 1'b1;
         S_WAIT: begin
            port_req = i_core_finished;
            port_dir = 1'b1;
         end
         S_SEND: begin
            port_req = 1'b1;
            port_dir = 1'b1;
         end
         default: ;
      endcase
   end

   uart_byte_port #(
      .RX_BASE     (RX_BASE),
      .TX_BASE     (TX_BASE),
      .STATUS_BASE (STATUS_BASE),
      .RRDY_BIT    (RRDY_BIT),
      .TRDY_BIT    (TRDY_BIT)
   ) u_port (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_req           (port_req),
      .i_dir           (port_dir),
      .i_tx_byte       (send_q[FIELD_W-9 -: 8]),
      .o_done          (port_done),
      .o_rx_byte       (port_rx),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_GET_N;
         cnt_q   <= '0;
         n_q     <= '0;
         d_q     <= '0;
         a_q     <= '0;
         send_q  <= '0;
         start_q <= 1'b0;
      end else begin
         start_q <= 1'b0;
         unique case (state_q)
            S_GET_N: begin
               if (port_done) begin
                  n_q <= {n_q[FIELD_W-9:0], port_rx};
                  if (key_last) begin
                     cnt_q   <= '0;
                     state_q <= S_GET_D;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_GET_D: begin
               if (port_done) begin
                  d_q <= {d_q[FIELD_W-9:0], port_rx};
                  if (key_last) begin
                     cnt_q   <= '0;
                     state_q <= S_GET_A;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_GET_A: begin
               if (port_done) begin
                  a_q <= {a_q[FIELD_W-9:0], port_rx};
                  if (key_last) begin
                     cnt_q   <= '0;
                     start_q <= 1'b1;
                     state_q <= S_START;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_START: state_q <= S_WAIT;
            S_WAIT: begin
               if (i_core_finished) begin
                  send_q  <= i_core_a_pow_d;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               if (port_done) begin
                  send_q <= {send_q[FIELD_W-9:0], 8'h00};
                  if (out_last) begin
                     cnt_q   <= '0;
                     state_q <= S_GET_A;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= S_GET_N;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_avalon_bridge.sv
module tb_rsa_avalon_bridge;

   typedef struct {
      logic [255:0] a;
      logic [255:0] res;
      int           stall;
      int           nr;
   } blk_t;

   localparam logic [255:0] KEY_N  =
      256'hCA3586E7_1B2C3D4E_5F607182_93A4B5C6_D7E8F901_12233445_56677889_9AABBCCD;
   localparam logic [255:0] KEY_D  =
      256'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [255:0] JUNK_X =
      256'h13579BDF_2468ACE0_13579BDF_2468ACE0_13579BDF_2468ACE0_13579BDF_2468ACE0;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic [4:0]   avm_address;
   logic         avm_read;
   logic [31:0]  avm_readdata;
   logic         avm_write;
   logic [31:0]  avm_writedata;
   logic         avm_waitrequest;
   logic         o_core_start;
   logic [255:0] o_core_a;
   logic [255:0] o_core_d;
   logic [255:0] o_core_n;
   logic [255:0] i_core_a_pow_d = '0;
   logic         i_core_finished = 1'b0;

   rsa_avalon_bridge dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .o_core_start    (o_core_start),
      .o_core_a        (o_core_a),
      .o_core_d        (o_core_d),
      .o_core_n        (o_core_n),
      .i_core_a_pow_d  (i_core_a_pow_d),
      .i_core_finished (i_core_finished)
   );

   always #5 i_clk = ~i_clk;

   // UART model state; each variable has a single writing process.
   logic [7:0] rx_mem [0:511];
   logic [7:0] tx_mem [0:511];
   int rx_wr = 0;       // initial block
   int stall_n = 0;     // initial block
   int notready = 0;    // initial block
   int rx_rd = 0, rx_clr = 0, tx_clr = 0, wcnt = 0, tx_cnt = 0, cyc = 0;
   int start_cnt = 0, start_lat = 0, last_rx_cyc = 0, fin_cyc = 0, poll_lat = 0;
   int proto_err = 0, gate_err = 0;
   bit held = 0, done_prev = 0, rx_ok = 0, tx_ok = 0, start_prev = 0, fin_pend = 0;
   logic [4:0]  h_addr;
   logic        h_read, h_write;
   logic [31:0] h_wdata;

   int n_tests = 0;
   int n_fail = 0;

   assign avm_waitrequest = (avm_read || avm_write) && (wcnt < stall_n);

   always_comb begin
      avm_readdata = 32'hDEAD_0000;
      if (avm_address == 5'd8) begin
         avm_readdata[7] = (rx_rd < rx_wr) && (rx_clr >= notready);
         avm_readdata[6] = (tx_clr >= notready);
      end else if (avm_address == 5'd0) begin
         avm_readdata[7:0] = rx_mem[rx_rd[8:0]];
      end
   end

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_rd      <= rx_wr;   // drop unread bytes of an aborted stream
         rx_clr     <= 0;
         tx_clr     <= 0;
         wcnt       <= 0;
         held       <= 0;
         done_prev  <= 0;
         rx_ok      <= 0;
         tx_ok      <= 0;
         start_prev <= 0;
         fin_pend   <= 0;
      end else begin
         cyc <= cyc + 1;
         if (avm_read && avm_write) proto_err <= proto_err + 1;
         if (held && (avm_address != h_addr || avm_read != h_read ||
                      avm_write != h_write || avm_writedata != h_wdata))
            proto_err <= proto_err + 1;
         if (done_prev && (avm_read || avm_write)) proto_err <= proto_err + 1;
         held      <= avm_waitrequest;
         h_addr    <= avm_address;
         h_read    <= avm_read;
         h_write   <= avm_write;
         h_wdata   <= avm_writedata;
         done_prev <= (avm_read || avm_write) && !avm_waitrequest;

         if (avm_waitrequest) begin
            wcnt <= wcnt + 1;
         end else if (avm_read || avm_write) begin
            wcnt <= 0;
            if (avm_read && avm_address == 5'd8) begin
               if (avm_readdata[7]) rx_ok <= 1;
               else if (rx_rd < rx_wr) rx_clr <= rx_clr + 1;
               if (avm_readdata[6]) tx_ok <= 1;
               else tx_clr <= tx_clr + 1;
            end else if (avm_read && avm_address == 5'd0) begin
               if (!rx_ok || rx_rd >= rx_wr) gate_err <= gate_err + 1;
               rx_rd       <= rx_rd + 1;
               rx_ok       <= 0;
               rx_clr      <= 0;
               last_rx_cyc <= cyc;
            end else if (avm_write && avm_address == 5'd4) begin
               if (!tx_ok) gate_err <= gate_err + 1;
               if (avm_writedata[31:8] != 24'h0) proto_err <= proto_err + 1;
               tx_mem[tx_cnt[8:0]] <= avm_writedata[7:0];
               tx_cnt <= tx_cnt + 1;
               tx_ok  <= 0;
               tx_clr <= 0;
            end else begin
               proto_err <= proto_err + 1;
            end
         end

         if (o_core_start) begin
            start_cnt <= start_cnt + 1;
            start_lat <= cyc - last_rx_cyc;
            if (start_prev) proto_err <= proto_err + 1;
         end
         start_prev <= o_core_start;

         if (i_core_finished) begin
            fin_cyc  <= cyc;
            fin_pend <= 1;
            tx_clr   <= 0;
         end else if (fin_pend && avm_read && avm_address == 5'd8) begin
            poll_lat <= cyc - fin_cyc;
            fin_pend <= 0;
         end
      end
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_bytes(input logic [255:0] v, input int count);
      for (int k = 0; k < count; k++) begin
         rx_mem[rx_wr[8:0]] = v[255 - 8*k -: 8];
         rx_wr = rx_wr + 1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},   256'(avm_address), 256'd8);
      check({tag, "_read"},   256'(avm_read), 256'd0);
      check({tag, "_write"},  256'(avm_write), 256'd0);
      check({tag, "_wdata"},  256'(avm_writedata), 256'd0);
      check({tag, "_start"},  256'(o_core_start), 256'd0);
      check({tag, "_core_n"}, o_core_n, 256'd0);
      check({tag, "_core_d"}, o_core_d, 256'd0);
      check({tag, "_core_a"}, o_core_a, 256'd0);
   endtask

   blk_t tbl [0:3];

   task automatic run_block(input int i, input bit load_keys);
      blk_t b;
      int base_s, base_t, c;
      bit ok;
      logic [7:0] exp_b;
      b = tbl[i];
      stall_n  = b.stall;
      notready = b.nr;
      base_s   = start_cnt;
      base_t   = tx_cnt;
      if (load_keys) begin
         push_bytes(KEY_N, 32);
         push_bytes(KEY_D, 32);
      end
      push_bytes(b.a, 32);

      ok = 0;
      for (c = 0; c < 20000 && !ok; c++) begin
         @(negedge i_clk);
         ok = (start_cnt > base_s);
      end
      check($sformatf("blk%0d_start_seen", i), 256'(ok), 256'd1);
      check($sformatf("blk%0d_core_a", i), o_core_a, b.a);
      check($sformatf("blk%0d_core_n", i), o_core_n, KEY_N);
      check($sformatf("blk%0d_core_d", i), o_core_d, KEY_D);
      check($sformatf("blk%0d_start_lat", i), 256'(start_lat), 256'd1);

      repeat (100) @(negedge i_clk);
      i_core_a_pow_d  = b.res;
      i_core_finished = 1'b1;
      @(negedge i_clk);
      i_core_finished = 1'b0;
      i_core_a_pow_d  = ~b.res;

      ok = 0;
      for (c = 0; c < 20000 && !ok; c++) begin
         @(negedge i_clk);
         ok = (tx_cnt >= base_t + 31);
      end
      check($sformatf("blk%0d_tx_seen", i), 256'(ok), 256'd1);
      repeat (30) @(negedge i_clk);
      check($sformatf("blk%0d_tx_count", i), 256'(tx_cnt - base_t), 256'd31);
      for (int k = 0; k < 31; k++) begin
         exp_b = b.res[247 - 8*k -: 8];
         check($sformatf("blk%0d_tx_byte%0d", i, k), 256'(tx_mem[(base_t + k) % 512]),
               256'(exp_b));
      end
      check($sformatf("blk%0d_poll_lat", i), 256'(poll_lat), 256'd1);
      check($sformatf("blk%0d_start_pulses", i), 256'(start_cnt - base_s), 256'd1);
      check($sformatf("blk%0d_protocol", i), 256'(proto_err), 256'd0);
      check($sformatf("blk%0d_gating", i), 256'(gate_err), 256'd0);
   endtask

   initial begin
      int base_s, base_t;
      bit ok;

      tbl[0] = '{a:   256'h01020304_05060708_090A0B0C_0D0E0F10_11121314_15161718_191A1B1C_1D1E1F20,
                 res: 256'h00112233_44556677_8899AABB_CCDDEEFF_00112233_44556677_8899AABB_CCDDEEFF,
                 stall: 0, nr: 0};
      tbl[1] = '{a:   256'hFEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_DEADBEEF_CAFEF00D,
                 res: 256'h7F00FF01_80C0E0F0_11111111_22222222_33333333_44444444_55555555_66666666,
                 stall: 3, nr: 0};
      tbl[2] = '{a:   256'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000042,
                 res: 256'hABFFEEDD_CCBBAA99_88776655_44332211_00012345_6789ABCD_EF012345_6789ABCD,
                 stall: 0, nr: 10};
      tbl[3] = '{a:   256'h5A5A5A5A_A5A5A5A5_C3C3C3C3_3C3C3C3C_0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0,
                 res: 256'hFFFFFFFF_00000000_FFFFFFFF_00000000_A5A55A5A_01020408_10204080_FEFDFBF7,
                 stall: 1, nr: 2};

      // Reset state.
      repeat (3) @(negedge i_clk);
      check_reset_outputs("reset");
      i_rst_n = 1'b1;

      // Abort while byte 17 of d is being received.
      push_bytes(JUNK_X, 32);
      push_bytes(JUNK_X, 20);
      ok = 0;
      for (int c = 0; c < 5000 && !ok; c++) begin
         @(negedge i_clk);
         ok = (rx_rd >= 48);
      end
      check("mid_d_reached", 256'(ok), 256'd1);
      repeat (2) @(negedge i_clk);
      check("mid_d_core_n_loaded", o_core_n, JUNK_X);
      i_rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;

      // Key load plus first block, then the remaining blocks reuse n and d.
      run_block(0, 1'b1);

      // A done indication while collecting ciphertext must be ignored.
      base_s = start_cnt;
      base_t = tx_cnt;
      i_core_a_pow_d  = 256'h1;
      i_core_finished = 1'b1;
      repeat (5) @(negedge i_clk);
      i_core_finished = 1'b0;
      repeat (40) @(negedge i_clk);
      check("stray_finished_tx", 256'(tx_cnt - base_t), 256'd0);
      check("stray_finished_start", 256'(start_cnt - base_s), 256'd0);
      check("stray_finished_core_a", o_core_a, tbl[0].a);

      for (int i = 1; i < 4; i++) run_block(i, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
